// File: rtl/alu_seq_pkg.sv
// alu_seq shared types: opcodes, FSM states
// and status flag bit positions.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_MUL = 4'h2,
    OP_DIV = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_NOT = 4'h7,
    OP_SHL = 4'h8,
    OP_SHR = 4'h9,
    OP_ASR = 4'hA,
    OP_SLT = 4'hB
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

  localparam int FL_Z   = 0;
  localparam int FL_C   = 1;
  localparam int FL_V   = 2;
  localparam int FL_N   = 3;
  localparam int FL_ERR = 4;
  localparam int FL_W   = 5;

  typedef logic [FL_W-1:0] flags_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative engine, one bit per
// cycle; shift-add multiply, restoring divide.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter  int W     = 8,
  localparam int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic [W-1:0]     r_lo;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_div;

  logic [W:0] w_madd;
  logic [W:0] w_shift;
  logic [W:0] w_trial;

  // MUL: conditional add of multiplicand to high half
  assign w_madd  = {1'b0, r_hi} +
                   (r_lo[0] ? {1'b0, r_b} : '0);
  // DIV: shift next dividend bit into remainder
  assign w_shift = {r_hi, r_lo[W-1]};
  assign w_trial = w_shift - {1'b0, r_b};

  // Load on start, then iterate W times; done pulses once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lo   <= '0;
      r_hi   <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_div  <= 1'b0;
    end else if (ena) begin
      r_done <= 1'b0;
      if (start) begin
        r_lo   <= a;
        r_hi   <= '0;
        r_b    <= b;
        r_div  <= is_div;
        r_cnt  <= CNT_W'(W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_div) begin
          if (!w_trial[W]) begin
            r_hi <= w_trial[W-1:0];
            r_lo <= {r_lo[W-2:0], 1'b1};
          end else begin
            r_hi <= w_shift[W-1:0];
            r_lo <= {r_lo[W-2:0], 1'b0};
          end
        end else begin
          {r_hi, r_lo} <= {w_madd, r_lo[W-1:1]};
        end
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign lo   = r_lo;
  assign hi   = r_hi;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshake,
// iterative MUL/DIV, status flags and accumulator.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int W     = 8,
  localparam int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [3:0]   opcode,
  input  logic         use_acc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [W-1:0] result_hi,
  output logic [4:0]   flags
);

  state_e       r_state;
  state_e       w_state_nx;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [3:0]   r_op;
  logic [W-1:0] r_acc;
  logic [W-1:0] r_res;
  logic [W-1:0] r_res_hi;
  flags_t       r_flags;

  logic         w_accept;
  logic         w_is_mul;
  logic         w_is_div;
  logic         w_div0;
  logic         w_start;
  logic [W-1:0] w_a_eff;
  logic         w_md_done;
  logic         w_xfer;

  logic         w_eng_busy;
  logic         w_eng_done;
  logic [W-1:0] w_eng_lo;
  logic [W-1:0] w_eng_hi;

  logic [W:0]       w_sum;
  logic [W:0]       w_dif;
  logic [W:0]       w_shl;
  logic [W:0]       w_shr;
  logic [W:0]       w_asr;
  logic [CNT_W-2:0] w_sh;

  logic [W-1:0] w_res;
  logic [W-1:0] w_res_hi;
  logic         w_c;
  logic         w_v;
  logic         w_err;
  flags_t       w_flags;
  flags_t       w_md_flags;

  assign in_ready  = ena & (r_state == ST_IDLE) &
                     ~w_eng_busy;
  assign out_valid = ena & (r_state == ST_DONE);

  assign w_accept = in_valid & in_ready;
  assign w_a_eff  = use_acc ? r_acc : op_a;
  assign w_is_mul = (opcode == OP_MUL);
  assign w_is_div = (opcode == OP_DIV);
  // Divide by zero bypasses the engine entirely
  assign w_div0   = w_is_div & (op_b == '0);
  assign w_start  = w_accept &
                    (w_is_mul | (w_is_div & ~w_div0));

  assign w_md_done = w_eng_done &
                     ((r_state == ST_MUL) |
                      (r_state == ST_DIV));
  assign w_xfer    = ena & out_ready &
                     (r_state == ST_DONE);

  alu_seq_muldiv #(.W(W)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .start  (w_start),
    .is_div (w_is_div),
    .a      (w_a_eff),
    .b      (op_b),
    .busy   (w_eng_busy),
    .done   (w_eng_done),
    .lo     (w_eng_lo),
    .hi     (w_eng_hi)
  );

  // State register; ena low holds the FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (ena) begin
      r_state <= w_state_nx;
    end
  end

  // Next-state sequencing
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_start)
            w_state_nx = w_is_mul ? ST_MUL : ST_DIV;
          else
            w_state_nx = ST_EXEC;
        end
      end
      ST_EXEC: w_state_nx = ST_DONE;
      ST_MUL:  if (w_eng_done) w_state_nx = ST_DONE;
      ST_DIV:  if (w_eng_done) w_state_nx = ST_DONE;
      ST_DONE: if (out_ready) w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};
  assign w_dif = {1'b0, r_a} - {1'b0, r_b};
  assign w_sh  = r_b[CNT_W-2:0];
  // Extra bit on the far side catches the last bit out
  assign w_shl = {1'b0, r_a} << w_sh;
  assign w_shr = {r_a, 1'b0} >> w_sh;
  assign w_asr = $signed({r_a, 1'b0}) >>> w_sh;

  // Single-cycle op decode, evaluated during EXEC
  always_comb begin
    w_res    = '0;
    w_res_hi = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_err    = 1'b0;
    unique case (1'b1)
      (r_op == OP_ADD): begin
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (r_a[W-1] == r_b[W-1]) &
                (w_sum[W-1] != r_a[W-1]);
      end
      (r_op == OP_SUB): begin
        w_res = w_dif[W-1:0];
        w_c   = w_dif[W];
        w_v   = (r_a[W-1] != r_b[W-1]) &
                (w_dif[W-1] != r_a[W-1]);
      end
      (r_op == OP_DIV): begin
        w_res    = '1;
        w_res_hi = r_a;
        w_err    = 1'b1;
      end
      (r_op == OP_AND): w_res = r_a & r_b;
      (r_op == OP_OR):  w_res = r_a | r_b;
      (r_op == OP_XOR): w_res = r_a ^ r_b;
      (r_op == OP_NOT): w_res = ~r_a;
      (r_op == OP_SHL): begin
        w_res = w_shl[W-1:0];
        w_c   = w_shl[W];
      end
      (r_op == OP_SHR): begin
        w_res = w_shr[W:1];
        w_c   = w_shr[0];
      end
      (r_op == OP_ASR): begin
        w_res = w_asr[W:1];
        w_c   = w_asr[0];
      end
      (r_op == OP_SLT): begin
        w_res = W'($signed(r_a) < $signed(r_b));
      end
      default: w_err = 1'b1;
    endcase
    w_flags         = '0;
    w_flags[FL_Z]   = (w_res == '0);
    w_flags[FL_N]   = w_res[W-1];
    w_flags[FL_C]   = w_c;
    w_flags[FL_V]   = w_v;
    w_flags[FL_ERR] = w_err;
  end

  // MUL/DIV results only set Z and N
  always_comb begin
    w_md_flags       = '0;
    w_md_flags[FL_Z] = (w_eng_lo == '0);
    w_md_flags[FL_N] = w_eng_lo[W-1];
  end

  // Operand capture, result registers, accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_res    <= '0;
      r_res_hi <= '0;
      r_flags  <= '0;
    end else if (ena) begin
      if (w_accept) begin
        r_a  <= w_a_eff;
        r_b  <= op_b;
        r_op <= opcode;
      end
      if (r_state == ST_EXEC) begin
        r_res    <= w_res;
        r_res_hi <= w_res_hi;
        r_flags  <= w_flags;
      end else if (w_md_done) begin
        r_res    <= w_eng_lo;
        r_res_hi <= w_eng_hi;
        r_flags  <= w_md_flags;
      end
      if (w_xfer && !r_flags[FL_ERR]) begin
        r_acc <= r_res;
      end
    end
  end

  assign result    = r_res;
  assign result_hi = r_res_hi;
  assign flags     = r_flags;

endmodule
